// File: rtl/stream_compactor_pkg.sv
// Shared types for the stream compactor: default beat width, byte-count type,
// transfer counter width and the control state enum.
package stream_compactor_pkg;

  localparam int unsigned BYTES_DEFAULT = 64;
  localparam int unsigned CNT_W_DEFAULT = $clog2(BYTES_DEFAULT) + 1;
  localparam int unsigned XFER_W        = 32;

  typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/stream_compactor_keep.sv
// keep_compactor: packs the kept bytes of a beat into lanes 0..n-1 in order.
// Each kept input lane lands at the output lane given by the number of kept
// lanes below it (prefix sum); unkept output lanes are zero.
module keep_compactor #(
  parameter int unsigned BYTES = 64,
  parameter int unsigned CNT_W = $clog2(BYTES) + 1
) (
  input  logic [8*BYTES-1:0] data,
  input  logic [BYTES-1:0]   keep,
  output logic [8*BYTES-1:0] cmp_data,
  output logic [CNT_W-1:0]   count
);

  logic [CNT_W-1:0] prefix [BYTES+1];

  // Running count of kept lanes below each lane
  always_comb begin
    prefix[0] = '0;
    for (int i = 0; i < BYTES; i++) begin
      prefix[i+1] = prefix[i] + CNT_W'(keep[i]);
    end
  end

  // Output lane j takes the kept input lane whose prefix equals j
  always_comb begin
    cmp_data = '0;
    for (int j = 0; j < BYTES; j++) begin
      for (int i = j; i < BYTES; i++) begin
        if (keep[i] && (prefix[i] == CNT_W'(j))) begin
          cmp_data[8*j +: 8] = data[8*i +: 8];
        end
      end
    end
  end

  assign count = prefix[BYTES];

endmodule

// File: rtl/stream_compactor.sv
// stream_compactor: removes sparse tkeep holes from an AXI-stream and repacks
// the bytes into dense beats. Optional transfer splitting (tlast at every
// 2^cfg_max_xfer_log2 emitted bytes) is built when STREAM_COMPACTOR_SPLIT_EN
// is defined; the default build has no cfg port and no transfer counter.
module stream_compactor
  import stream_compactor_pkg::*;
#(
  parameter int unsigned BYTES = BYTES_DEFAULT,
  parameter int unsigned CNT_W = $clog2(BYTES) + 1
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               enable,
  input  logic [8*BYTES-1:0] s_tdata,
  input  logic [BYTES-1:0]   s_tkeep,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  output logic               s_tready,
  output logic [8*BYTES-1:0] m_tdata,
  output logic [BYTES-1:0]   m_tkeep,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  output logic [CNT_W-1:0]   m_count
`ifdef STREAM_COMPACTOR_SPLIT_EN
  ,
  input  logic [4:0]         cfg_max_xfer_log2
`endif
);

  localparam int unsigned DATA_W = 8 * BYTES;
  localparam int unsigned LOG2_B = $clog2(BYTES);

  state_e             state;
  logic [DATA_W-1:0]  stage_data;
  logic [CNT_W-1:0]   stage_n;
  logic               stage_last;
  logic               stage_valid;
  logic [DATA_W-1:0]  acc_data;
  logic [CNT_W-1:0]   acc_cnt;

  logic [DATA_W-1:0]  cmp_data;
  logic [CNT_W-1:0]   cmp_n;
  logic [2*DATA_W-1:0] comb_data;
  logic [CNT_W-1:0]   total;
  logic               out_free;
  logic               consume;
  logic               accept;
  logic               do_last;
  logic               do_full;
  logic               do_flush;
  logic               split_hit;

  function automatic logic [BYTES-1:0] low_mask(input logic [CNT_W-1:0] n);
    logic [BYTES-1:0] m;
    for (int i = 0; i < BYTES; i++) begin
      m[i] = (CNT_W'(i) < n);
    end
    return m;
  endfunction

  keep_compactor #(
    .BYTES (BYTES),
    .CNT_W (CNT_W)
  ) u_keep_compactor (
    .data     (s_tdata),
    .keep     (s_tkeep),
    .cmp_data (cmp_data),
    .count    (cmp_n)
  );

  // Handshake and merge decision for the current cycle
  always_comb begin
    out_free  = !m_tvalid || m_tready;
    consume   = (state == ACCUM) && stage_valid && out_free;
    s_tready  = !areset && enable && (state == ACCUM) && (!stage_valid || consume);
    accept    = s_tvalid && s_tready;
    total     = acc_cnt + stage_n;
    comb_data = {{DATA_W{1'b0}}, acc_data}
              | ({{DATA_W{1'b0}}, stage_data} << {acc_cnt, 3'b000});
    do_last   = consume && stage_last && (total <= CNT_W'(BYTES));
    do_full   = consume && !do_last && (total >= CNT_W'(BYTES));
    do_flush  = (state == FLUSH) && out_free;
  end

`ifdef STREAM_COMPACTOR_SPLIT_EN
  logic [XFER_W-1:0] xfer_cnt;
  logic [XFER_W-1:0] xfer_mask;
  logic [XFER_W-1:0] xfer_next;
  logic [4:0]        eff_log2;

  // Transfer boundary detection; sizes below one beat clamp to one beat
  always_comb begin
    eff_log2  = (cfg_max_xfer_log2 < 5'(LOG2_B)) ? 5'(LOG2_B) : cfg_max_xfer_log2;
    xfer_mask = (XFER_W'(1) << eff_log2) - XFER_W'(1);
    xfer_next = xfer_cnt + XFER_W'(BYTES);
    split_hit = ((xfer_next & xfer_mask) == '0);
  end

  // Bytes emitted in the current transfer, cleared at each packet end
  always_ff @(posedge aclk) begin
    if (areset) begin
      xfer_cnt <= '0;
    end else if (do_last || do_flush) begin
      xfer_cnt <= '0;
    end else if (do_full) begin
      xfer_cnt <= xfer_next;
    end
  end
`else
  assign split_hit = 1'b0;
`endif

  // Stage, accumulator, control state and output register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= ACCUM;
      stage_data  <= '0;
      stage_n     <= '0;
      stage_last  <= 1'b0;
      stage_valid <= 1'b0;
      acc_data    <= '0;
      acc_cnt     <= '0;
      m_tdata     <= '0;
      m_tkeep     <= '0;
      m_tvalid    <= 1'b0;
      m_tlast     <= 1'b0;
      m_count     <= '0;
    end else begin
      if (m_tvalid && m_tready) begin
        m_tvalid <= 1'b0;
      end

      if (accept) begin
        stage_data  <= cmp_data;
        stage_n     <= cmp_n;
        stage_last  <= s_tlast;
        stage_valid <= 1'b1;
      end else if (consume) begin
        stage_valid <= 1'b0;
      end

      case (state)
        ACCUM: begin
          if (do_last) begin
            m_tvalid <= 1'b1;
            m_tdata  <= comb_data[DATA_W-1:0];
            m_tkeep  <= low_mask(total);
            m_count  <= total;
            m_tlast  <= 1'b1;
            acc_data <= '0;
            acc_cnt  <= '0;
          end else if (do_full) begin
            m_tvalid <= 1'b1;
            m_tdata  <= comb_data[DATA_W-1:0];
            m_tkeep  <= '1;
            m_count  <= CNT_W'(BYTES);
            m_tlast  <= split_hit;
            acc_data <= comb_data[2*DATA_W-1:DATA_W];
            acc_cnt  <= total - CNT_W'(BYTES);
            if (stage_last) begin
              state <= FLUSH;
            end
          end else if (consume) begin
            acc_data <= comb_data[DATA_W-1:0];
            acc_cnt  <= total;
          end
        end
        FLUSH: begin
          if (do_flush) begin
            m_tvalid <= 1'b1;
            m_tdata  <= acc_data;
            m_tkeep  <= low_mask(acc_cnt);
            m_count  <= acc_cnt;
            m_tlast  <= 1'b1;
            acc_data <= '0;
            acc_cnt  <= '0;
            state    <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_compactor.sv
// Testbench for stream_compactor: directed scenarios plus randomized traffic,
// scored against a byte-queue reference model. Define STREAM_COMPACTOR_SPLIT_EN
// to also exercise transfer splitting.
module tb_stream_compactor;
  import stream_compactor_pkg::*;

  localparam int unsigned B  = 64;
  localparam int unsigned CW = $clog2(B) + 1;
  localparam int unsigned DW = 8 * B;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [B-1:0]  keep;
    logic          last;
    logic [CW-1:0] count;
  } beat_t;

  logic          aclk;
  logic          areset;
  logic          enable;
  logic [DW-1:0] s_tdata;
  logic [B-1:0]  s_tkeep;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [B-1:0]  m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [CW-1:0] m_count;
`ifdef STREAM_COMPACTOR_SPLIT_EN
  logic [4:0]    cfg_max_xfer_log2;
`endif

  stream_compactor #(
    .BYTES (B),
    .CNT_W (CW)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .enable   (enable),
    .s_tdata  (s_tdata),
    .s_tkeep  (s_tkeep),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tready (m_tready),
    .m_count  (m_count)
`ifdef STREAM_COMPACTOR_SPLIT_EN
    ,
    .cfg_max_xfer_log2 (cfg_max_xfer_log2)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int         compared = 0;
  int         mism     = 0;
  logic [7:0] pend[$];
  beat_t      exp_q[$];
  int         obs_log[$];
  int         stall_cnt;
  int         out_beats;
  int         hold_cycles;
  bit         rnd_ready;
  bit         rnd_en;
  bit         got_accept;
  bit         hold_valid;
  beat_t      held;
  longint     xfer;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [B-1:0] lowk(input int n);
    logic [B-1:0] k;
    for (int i = 0; i < B; i++) k[i] = (i < n);
    return k;
  endfunction

  // Reference model: a byte FIFO cut into beats by the packing rules
  function automatic bit split_at(input longint sent);
`ifdef STREAM_COMPACTOR_SPLIT_EN
    int e;
    e = (int'(cfg_max_xfer_log2) < $clog2(B)) ? $clog2(B) : int'(cfg_max_xfer_log2);
    return (sent % (64'd1 << e)) == 0;
`else
    return (sent < 0);
`endif
  endfunction

  function automatic void model_emit(input int n, input bit last);
    beat_t e;
    e = '0;
    for (int i = 0; i < n; i++) begin
      e.data[8*i +: 8] = pend.pop_front();
      e.keep[i] = 1'b1;
    end
    e.last  = last;
    e.count = CW'(n);
    exp_q.push_back(e);
  endfunction

  function automatic void model_accept(input logic [DW-1:0] d, input logic [B-1:0] k, input logic last);
    for (int i = 0; i < B; i++) if (k[i]) pend.push_back(d[8*i +: 8]);
    if (last) begin
      while (pend.size() > B) begin
        xfer += B;
        model_emit(B, split_at(xfer));
      end
      model_emit(pend.size(), 1'b1);
      xfer = 0;
    end else begin
      while (pend.size() >= B) begin
        xfer += B;
        model_emit(B, split_at(xfer));
      end
    end
  endfunction

  // Observe the handshakes that the coming clock edge will complete
  task automatic observe();
    beat_t e;
    got_accept = 1'b0;
    if (areset) begin
      pend.delete();
      exp_q.delete();
      xfer = 0;
      hold_valid = 1'b0;
      return;
    end
    if (hold_valid) begin
      chk("hold_valid", 64'(m_tvalid), 64'(1));
      chkw("hold_data", m_tdata, held.data);
      chk("hold_keep", 64'(m_tkeep), 64'(held.keep));
      chk("hold_last_count", 64'({m_tlast, m_count}), 64'({held.last, held.count}));
    end
    if (s_tvalid && s_tready) begin
      model_accept(s_tdata, s_tkeep, s_tlast);
      got_accept = 1'b1;
    end else if (s_tvalid) begin
      stall_cnt++;
    end
    if (m_tvalid && m_tready) begin
      chk("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chkw("sb_data", m_tdata, e.data);
        chk("sb_keep", 64'(m_tkeep), 64'(e.keep));
        chk("sb_last", 64'(m_tlast), 64'(e.last));
        chk("sb_count", 64'(m_count), 64'(e.count));
      end
      out_beats++;
      obs_log.push_back(int'(m_count) * 2 + int'(m_tlast));
    end
    hold_valid = m_tvalid && !m_tready;
    held.data  = m_tdata;
    held.keep  = m_tkeep;
    held.last  = m_tlast;
    held.count = m_count;
  endtask

  task automatic cycle();
    if (hold_cycles > 0) begin
      m_tready = 1'b0;
      hold_cycles--;
    end else if (rnd_ready) begin
      m_tready = ($urandom_range(0, 3) != 0);
    end else begin
      m_tready = 1'b1;
    end
    enable = rnd_en ? ($urandom_range(0, 7) != 0) : 1'b1;
    #1;
    observe();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [B-1:0] keep, input logic last, input string tag);
    int budget;
    budget   = 200;
    s_tdata  = rand_data();
    s_tkeep  = keep;
    s_tlast  = last;
    s_tvalid = 1'b1;
    do begin
      cycle();
      budget--;
    end while (!got_accept && budget > 0);
    s_tvalid = 1'b0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    chk({tag, "_accept"}, 64'(got_accept), 64'(1));
  endtask

  task automatic drain(input string tag);
    int budget;
    budget    = 400;
    rnd_ready = 1'b0;
    rnd_en    = 1'b0;
    while (exp_q.size() > 0 && budget > 0) begin
      cycle();
      budget--;
    end
    repeat (3) cycle();
    chk({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic start_scenario();
    out_beats = 0;
    stall_cnt = 0;
    obs_log.delete();
  endtask

  initial begin
    logic [B-1:0] k;
    areset      = 1'b1;
    enable      = 1'b1;
    s_tdata     = '0;
    s_tkeep     = '0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    m_tready    = 1'b0;
    hold_cycles = 0;
    rnd_ready   = 1'b0;
    rnd_en      = 1'b0;
    hold_valid  = 1'b0;
    xfer        = 0;
`ifdef STREAM_COMPACTOR_SPLIT_EN
    cfg_max_xfer_log2 = 5'd31;
`endif

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_m_tlast", 64'(m_tlast), 64'(0));
    chk("rst_m_tkeep", 64'(m_tkeep), 64'(0));
    chkw("rst_m_tdata", m_tdata, '0);
    chk("rst_m_count", 64'(m_count), 64'(0));
    areset = 1'b0;

    // Four half-density beats then packet end: two full beats, last one tlast
    start_scenario();
    for (int i = 0; i < B; i++) k[i] = ((i % 8) < 4);
    for (int b = 0; b < 4; b++) send(k, (b == 3), "s1");
    drain("s1");
    chk("s1_beats", 64'(out_beats), 64'(2));
    chk("s1_beat0", 64'(obs_log[0]), 64'(64 * 2 + 0));
    chk("s1_beat1", 64'(obs_log[1]), 64'(64 * 2 + 1));

    // Alternating keep: one full beat of even bytes
    start_scenario();
    for (int i = 0; i < B; i++) k[i] = ((i % 2) == 0);
    send(k, 1'b0, "s2a");
    send(k, 1'b0, "s2b");
    drain("s2");
    chk("s2_beats", 64'(out_beats), 64'(1));
    chk("s2_beat0", 64'(obs_log[0]), 64'(64 * 2 + 0));

    // 40 + 40 with tlast: full beat, then 16-byte tlast beat via flush
    start_scenario();
    send(lowk(40), 1'b0, "s3a");
    send(lowk(40), 1'b1, "s3b");
    send('1, 1'b0, "s3c");
    send('1, 1'b0, "s3d");
    chk("s3_stall", 64'(stall_cnt), 64'(1));
    send('0, 1'b1, "s3e");
    drain("s3");
    chk("s3_beats", 64'(out_beats), 64'(5));
    chk("s3_beat0", 64'(obs_log[0]), 64'(64 * 2 + 0));
    chk("s3_beat1", 64'(obs_log[1]), 64'(16 * 2 + 1));
    chk("s3_beat4", 64'(obs_log[4]), 64'(0 * 2 + 1));

    // Output backpressure for 10 cycles while streaming
    start_scenario();
    hold_cycles = 10;
    for (int b = 0; b < 6; b++) send('1, (b == 5), "s4");
    drain("s4");
    chk("s4_stall_seen", 64'(stall_cnt > 0), 64'(1));
    chk("s4_beats", 64'(out_beats), 64'(6));

`ifdef STREAM_COMPACTOR_SPLIT_EN
    // 128-byte transfers: tlast on beats 2, 4 and 5
    start_scenario();
    cfg_max_xfer_log2 = 5'd7;
    for (int b = 0; b < 5; b++) send('1, (b == 4), "s5");
    drain("s5");
    chk("s5_beat0", 64'(obs_log[0]), 64'(128));
    chk("s5_beat1", 64'(obs_log[1]), 64'(129));
    chk("s5_beat2", 64'(obs_log[2]), 64'(128));
    chk("s5_beat3", 64'(obs_log[3]), 64'(129));
    chk("s5_beat4", 64'(obs_log[4]), 64'(129));
    cfg_max_xfer_log2 = 5'd31;
`endif

    // Reset with 20 bytes accumulated; next packet carries no stale bytes
    start_scenario();
    send(lowk(20), 1'b0, "s6a");
    cycle();
    cycle();
    areset = 1'b1;
    #1;
    chk("s6_rst_ready", 64'(s_tready), 64'(0));
    cycle();
    chk("s6_rst_valid", 64'(m_tvalid), 64'(0));
    chk("s6_rst_count", 64'(m_count), 64'(0));
    areset = 1'b0;
    start_scenario();
    send(lowk(30), 1'b1, "s6b");
    send('0, 1'b1, "s6c");
    drain("s6");
    chk("s6_beats", 64'(out_beats), 64'(2));
    chk("s6_beat0", 64'(obs_log[0]), 64'(30 * 2 + 1));
    chk("s6_empty_last", 64'(obs_log[1]), 64'(0 * 2 + 1));

    // Randomized traffic with random backpressure and enable
    start_scenario();
`ifdef STREAM_COMPACTOR_SPLIT_EN
    cfg_max_xfer_log2 = 5'($urandom_range(0, 9));
`endif
    rnd_ready = 1'b1;
    rnd_en    = 1'b1;
    for (int b = 0; b < 300; b++) begin
      case ($urandom_range(0, 4))
        0:       k = '1;
        1:       k = '0;
        2:       k = lowk(int'($urandom_range(0, B)));
        default: begin
          k[31:0]  = $urandom();
          k[63:32] = $urandom();
        end
      endcase
      send(k, ($urandom_range(0, 3) == 0), "rnd");
    end
    send('1, 1'b1, "rnd_end");
    drain("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule

// File: doc/stream_compactor.md
STREAM_COMPACTOR -- requirements
Module: stream_compactor

Interface
REQ-001 SHALL have parameter BYTES, default 64, bytes per beat: a power of 2 from 4 to 128.
REQ-002 SHALL have parameter CNT_W, default $clog2(BYTES)+1, the byte-count width.
REQ-003 SHALL have ports, each as name, direction, width, meaning:
- aclk, in, 1: sole clock.
- areset, in, 1: reset; one clock, synchronous, active-high.
- enable, in, 1: when 0, input acceptance is frozen and the output still drains.
- s_tdata, in, 8*BYTES: input data.
- s_tkeep, in, BYTES: sparse byte enables; any pattern is legal.
- s_tvalid, in, 1: input valid.
- s_tlast, in, 1: end of packet.
- s_tready, out, 1: input ready.
- m_tdata, out, 8*BYTES: output data.
- m_tkeep, out, BYTES: output byte enables.
- m_tvalid, out, 1: output valid.
- m_tlast, out, 1: end of packet or end of transfer.
- m_tready, in, 1: output ready.
- m_count, out, CNT_W: number of valid bytes in the current m beat.
- cfg_max_xfer_log2, in, 5: log2 of the maximum transfer size in bytes; present only with the macro in REQ-017.

Function
REQ-004 SHALL accept an input beat when s_tvalid & s_tready are both 1; s_tready = enable & (stage empty | stage consumed this cycle).
REQ-005 SHALL compact the kept bytes of each accepted beat to lanes 0..n-1, preserving byte order, into a stage register; n = popcount(s_tkeep).
REQ-006 SHALL append the stage bytes behind the acc_cnt residual bytes (0..BYTES-1) held in the accumulator.
REQ-007 SHALL, in state ACCUM, consume the stage when the output register is empty or m_tready=1, as follows:
- acc_cnt+n < BYTES, no tlast: no output; acc_cnt += n.
- acc_cnt+n >= BYTES: emit a full beat (keep all ones, tlast 0); residual = acc_cnt+n-BYTES.
- tlast and acc_cnt+n <= BYTES: emit all bytes, keep = low acc_cnt+n ones, tlast 1; acc_cnt = 0.
- tlast and acc_cnt+n > BYTES: emit a full beat with tlast 0, then go to FLUSH.
REQ-008 SHALL, in FLUSH, hold the stage unconsumed and s_tready 0, emit the residual with tlast 1, then return to ACCUM with acc_cnt = 0.
REQ-009 SHALL emit a tlast beat with keep 0 and m_count 0 when a tlast beat arrives with n=0 and acc_cnt=0.
REQ-010 SHALL hold m_tdata, m_tkeep, m_tlast and m_count stable while m_tvalid=1 and m_tready=0.
REQ-011 SHALL drive unkept output lanes to zero.
REQ-012 SHALL have a minimum latency of 2 cycles from input acceptance to m_tvalid for a completing beat.
REQ-013 SHALL sustain one input beat per cycle when m_tready=1 and no FLUSH occurs.
REQ-014 SHALL let each m_tkeep be a contiguous low mask with m_count = popcount(m_tkeep).

Reset
REQ-015 SHALL, while areset=1 at a clock edge, clear the following: m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0, m_count=0, acc_cnt=0, stage empty, state ACCUM, transfer byte counter=0.
REQ-016 SHALL discard any partial packet held at reset and drive s_tready 0 during reset.

Configuration
REQ-017 SHALL compile the transfer splitting of REQ-018 and REQ-019 only when macro STREAM_COMPACTOR_SPLIT_EN is defined.
REQ-018 SHALL, with the macro, count emitted bytes per transfer and assert m_tlast on the full beat where the count reaches a multiple of 2^cfg_max_xfer_log2.
REQ-019 SHALL, with the macro, reset the transfer byte counter at every packet-end tlast, and treat cfg_max_xfer_log2 < log2(BYTES) as equal to log2(BYTES).
REQ-020 SHALL, without the macro, omit cfg_max_xfer_log2 and the byte counter, and assert m_tlast only at packet end.

Structure
REQ-021 SHALL put BYTES_DEFAULT, the count typedef and the state enum (ACCUM, FLUSH) in the shared package stream_compactor_pkg.
REQ-022 SHALL implement the compaction of REQ-005 in a sub-module keep_compactor, using a prefix-sum lane select, combinational, parametrised by BYTES.

Verification
REQ-023 SHALL cover the following directed scenarios at BYTES=64:
- Beats with keep 0x0F..0F (32 bytes) ×4 then tlast → two full beats; the second has tlast=1 and m_count=64.
- Alternating keep 0x5555..55 ×2 → one full beat whose bytes are the even input bytes in order.
- 40-byte beat then a 40-byte tlast beat → full beat with tlast=0, then a 16-byte beat with tlast=1; s_tready=0 for one cycle.
- m_tready held 0 for 10 cycles while streaming → outputs stable, s_tready drops, no loss or duplication.
- Splitting macro, cfg_max_xfer_log2=7, 5 full beats with tlast on the last → m_tlast on beats 2, 4 and 5.
- areset pulsed with 20 bytes accumulated → m_tvalid=0, the next packet is output with no stale bytes; a tlast beat with keep 0 yields an empty tlast beat.
